// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer directly downstream of the UART receiver.
// Captures a word on each rising edge of the receiver's data-ready strobe and stores it in a
// DEPTH-entry circular FIFO. The head word is presented first-word-fall-through.
//
// Ports:
//   nrst_in         asynchronous active-low reset
//   divclk_in       clock shared with the UART receiver
//   rx_data_in      received word, valid while rx_rdy_in is high
//   rx_rdy_in       receiver data-ready (one push per rising edge)
//   clear_in        synchronous flush; empties the FIFO and clears overflow
//   data_out        head-of-queue word, meaningful while data_valid_out is high
//   data_valid_out  FIFO non-empty
//   data_ready_in   consumer accept; pop when data_valid_out & data_ready_in
//   count_out       number of stored words, 0..DEPTH
//   full_out        count_out == DEPTH
//   empty_out       count_out == 0
//   overflow_out    sticky: a word was dropped because the FIFO was full
module uart_rx_fifo #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned DEPTH     = 16,
   localparam int unsigned AW       = $clog2(DEPTH)
) (
   input  logic                 nrst_in,
   input  logic                 divclk_in,
   input  logic [DATA_BITS-1:0] rx_data_in,
   input  logic                 rx_rdy_in,
   input  logic                 clear_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid_out,
   input  logic                 data_ready_in,
   output logic [AW:0]          count_out,
   output logic                 full_out,
   output logic                 empty_out,
   output logic                 overflow_out
);

   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [DATA_BITS-1:0] mem [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [AW:0]          count_q, count_d;
   logic                 overflow_q, overflow_d;
   logic                 rdy_q;
   logic                 push_req, push_ok, pop, wr_en;

   assign full_out       = (count_q == FULL_COUNT);
   assign empty_out      = (count_q == '0);
   assign data_valid_out = ~empty_out;
   assign count_out      = count_q;
   assign overflow_out   = overflow_q;
   assign data_out       = mem[rd_ptr_q];

   always_comb begin
      push_req   = rx_rdy_in & ~rdy_q;
      pop        = data_valid_out & data_ready_in;
      // A pop in the same cycle frees the slot the push lands in.
      push_ok    = push_req & (~full_out | pop);
      wr_en      = push_ok & ~clear_in;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (clear_in) begin
         // Flush wins over push and pop; a discarded push is not an overflow.
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
         unique case ({push_ok, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
         endcase
         if (push_req & ~push_ok) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge divclk_in or negedge nrst_in) begin
      if (!nrst_in) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         // Tracks the strobe even during a flush so a held strobe cannot re-push.
         rdy_q      <= rx_rdy_in;
      end
   end

   // Storage is not reset.
   always_ff @(posedge divclk_in) begin
      if (wr_en) mem[wr_ptr_q] <= rx_data_in;
   end

endmodule
